// File: rtl/tdm_pkg.sv
// Shared types and constants for the two-channel TDM receive path.
package tdm_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  function automatic int frame_len(input int width);
    return 2 * width;
  endfunction

  localparam int FRAME_LEN = frame_len(DEF_WIDTH);

endpackage

// File: rtl/tdm_chan_shift.sv
// Per-channel MSB-first shift register; clear+enable together restarts the word with din.
module tdm_chan_shift
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= en ? {{(WIDTH-1){1'b0}}, din} : '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/tdm_demux2_1.sv
// 2:1 TDM demultiplexer: hunts for sync, deinterleaves A/B bits, and presents
// both words through a single valid/ready holding register.
module tdm_demux2_1
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             sync_err
);

  localparam int FLEN = frame_len(WIDTH);
  localparam int CW   = $clog2(FLEN);
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic start;
  logic data_bit;
  logic shift_a;
  logic shift_b;
  logic complete;
  logic load;

  // A sync always restarts the frame, whether hunting or mid-frame.
  assign start    = din_valid && frame_sync;
  assign data_bit = din_valid && !frame_sync && (state == RECV);
  assign shift_a  = start || (data_bit && !bit_cnt[0]);
  assign shift_b  = data_bit && bit_cnt[0];
  assign complete = data_bit && (bit_cnt == LAST);
  assign load     = complete && (!out_valid || out_ready);

  tdm_chan_shift #(.WIDTH(WIDTH)) u_shift_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_a),
    .clr   (start),
    .din   (din),
    .q     (a_q)
  );

  tdm_chan_shift #(.WIDTH(WIDTH)) u_shift_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_b),
    .clr   (start),
    .din   (din),
    .q     (b_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= start && (state == RECV) && (bit_cnt != '0);

      if (start) begin
        state   <= RECV;
        bit_cnt <= CW'(1);
      end else if (data_bit) begin
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
      end

      // The last B bit is still on din, so fold it in directly on load.
      if (load) begin
        out_a     <= a_q;
        out_b     <= {b_q[WIDTH-2:0], din};
        out_valid <= 1'b1;
      end else begin
        if (complete) begin
          overrun <= 1'b1;
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux2_1.sv
// Directed bench for tdm_demux2_1 with a queue-based frame model checked every cycle.
module tb_tdm_demux2_1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         out_valid;
  logic         overrun;
  logic         sync_err;

  int tests = 0;
  int fails = 0;

  tdm_demux2_1 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Model: collected frame bits since the last sync; words rebuilt once 2*W arrive.
  bit           fbits[$];
  bit           m_locked;
  logic [W-1:0] m_a, m_b, na, nb;
  logic         m_valid, m_over, m_serr, done;

  task automatic model_reset();
    fbits.delete();
    m_locked = 0;
    m_a = '0; m_b = '0;
    m_valid = 0; m_over = 0; m_serr = 0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    done = 0;
    m_serr = 0;
    if (din_valid) begin
      if (frame_sync) begin
        if (m_locked && fbits.size() != 0) m_serr = 1;
        fbits.delete();
        fbits.push_back(din);
        m_locked = 1;
      end else if (m_locked) begin
        fbits.push_back(din);
        if (fbits.size() == 2 * W) begin
          na = '0; nb = '0;
          for (int i = 0; i < W; i++) begin
            na[W-1-i] = fbits[2*i];
            nb[W-1-i] = fbits[2*i+1];
          end
          fbits.delete();
          done = 1;
        end
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_a = na; m_b = nb; m_valid = 1;
      end else begin
        m_over = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every cycle out of reset, DUT against model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        tests++;
        if (out_valid !== m_valid || out_a !== m_a || out_b !== m_b ||
            overrun !== m_over || sync_err !== m_serr) begin
          fails++;
          $display("FAIL model t=%0t: got v=%b a=%h b=%h ov=%b se=%b expected v=%b a=%h b=%h ov=%b se=%b",
                   $time, out_valid, out_a, out_b, overrun, sync_err,
                   m_valid, m_a, m_b, m_over, m_serr);
        end
      end
    end
  end

  // Called just after a negedge; returns at the following negedge.
  task automatic step(input logic d, input logic dv, input logic fs, input logic rdy);
    din = d; din_valid = dv; frame_sync = fs; out_ready = rdy;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic send_part(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int lo, input int hi, input logic sync_lo,
                           input logic rdy, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      step((i % 2 == 0) ? a[W-1-i/2] : b[W-1-i/2], 1'b1, sync_lo && (i == lo), rdy);
      if (gaps) step(1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_a", {24'd0, out_a}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);

    // Basic frame A5/3C.
    send_part(8'hA5, 8'h3C, 0, 15, 1'b1, 1'b1, 0);
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    check("basic_a", {24'd0, out_a}, 32'hA5);
    check("basic_b", {24'd0, out_b}, 32'h3C);
    check("basic_overrun", {31'd0, overrun}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_consumed", {31'd0, out_valid}, 32'd0);

    // Back-to-back with no consumer: second frame dropped.
    do_reset();
    send_part(8'h12, 8'h34, 0, 15, 1'b1, 1'b0, 0);
    send_part(8'h56, 8'h78, 0, 15, 1'b0, 1'b0, 0);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_a", {24'd0, out_a}, 32'h12);
    check("ovr_b", {24'd0, out_b}, 32'h34);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_drain_valid", {31'd0, out_valid}, 32'd0);
    check("ovr_drain_a", {24'd0, out_a}, 32'h12);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Mid-frame sync.
    do_reset();
    send_part(8'hC3, 8'h99, 0, 4, 1'b1, 1'b1, 0);
    send_part(8'hFF, 8'h00, 0, 0, 1'b1, 1'b1, 0);
    check("serr_pulse", {31'd0, sync_err}, 32'd1);
    send_part(8'hFF, 8'h00, 1, 15, 1'b0, 1'b1, 0);
    check("serr_a", {24'd0, out_a}, 32'hFF);
    check("serr_b", {24'd0, out_b}, 32'h00);
    check("serr_gone", {31'd0, sync_err}, 32'd0);

    // din_valid toggling.
    do_reset();
    send_part(8'hA5, 8'h3C, 0, 15, 1'b1, 1'b0, 1);
    check("gap_valid", {31'd0, out_valid}, 32'd1);
    check("gap_a", {24'd0, out_a}, 32'hA5);
    check("gap_b", {24'd0, out_b}, 32'h3C);

    // No sync after reset.
    do_reset();
    send_part(8'hA5, 8'h3C, 0, 15, 1'b0, 1'b1, 0);
    check("nosync_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-frame, then resync.
    do_reset();
    send_part(8'h11, 8'h22, 0, 15, 1'b1, 1'b0, 0);
    send_part(8'hEE, 8'hDD, 0, 8, 1'b1, 1'b0, 0);
    rst_n = 0;
    model_reset();
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_a", {24'd0, out_a}, 32'd0);
    check("rst_mid_b", {24'd0, out_b}, 32'd0);
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1;
    send_part(8'hC3, 8'h5A, 0, 15, 1'b1, 1'b1, 0);
    check("resync_a", {24'd0, out_a}, 32'hC3);
    check("resync_b", {24'd0, out_b}, 32'h5A);

    // Completion coincides with acceptance of the previous word.
    do_reset();
    send_part(8'hA5, 8'h3C, 0, 15, 1'b1, 1'b0, 0);
    send_part(8'h0F, 8'hF0, 0, 14, 1'b0, 1'b0, 0);
    check("coinc_hold_a", {24'd0, out_a}, 32'hA5);
    send_part(8'h0F, 8'hF0, 15, 15, 1'b0, 1'b1, 0);
    check("coinc_valid", {31'd0, out_valid}, 32'd1);
    check("coinc_a", {24'd0, out_a}, 32'h0F);
    check("coinc_b", {24'd0, out_b}, 32'hF0);
    check("coinc_overrun", {31'd0, overrun}, 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
